sm_imem_loadable: RTL and testbench

//  Per-node instruction memory for the multicore schoolRISCV array. Word-addressed, parametrised in width/depth.

---
 rtl/sm_imem_pkg.sv | 18 +
 rtl/sm_imem_ram.sv | 33 +++
 rtl/sm_imem.sv | 133 +++++++++++++
 tb/tb_sm_imem_loadable.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_imem_pkg.sv
// Shared definitions for the loadable instruction memory: loader FSM states,
// the canonical RISC-V NOP and the even-parity helper.
package sm_imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h00000013;

  // Even parity over up to 64 bits; callers zero-extend narrower words.
  function automatic logic even_parity(input logic [63:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/sm_imem_ram.sv
// Simple dual-port RAM: one write port for the loader, one registered read port
// for instruction fetch. The array itself is never reset so contents survive rst_n.
module sm_imem_ram #(
  parameter int W      = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register only updates on a read so the last word is held between fetches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_reg <= '0;
    else if (re) rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/sm_imem.sv
// Runtime-loadable per-node instruction memory with core hold during loads.
// Optional per-word even parity is enabled by defining SM_IMEM_PARITY_EN.
module sm_imem_loadable
  import sm_imem_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 128,
  parameter int ADDR_W        = $clog2(DEPTH),
  parameter int NODE_ID       = 0,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              core_hold,
  output logic [7:0]        node_id
);

`ifdef SM_IMEM_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [ADDR_W:0]   cnt_reg, cnt_next;
  logic              hold_reg, hold_next;
  logic              zdone_reg, zdone_next;
  logic              f_rvalid_reg;
  logic              we, re;
  logic [RAM_W-1:0]  wdata, rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      cnt_reg      <= '0;
      hold_reg     <= HOLD_AT_RESET;
      zdone_reg    <= 1'b0;
      f_rvalid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      cnt_reg      <= cnt_next;
      hold_reg     <= hold_next;
      zdone_reg    <= zdone_next;
      f_rvalid_reg <= re;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    hold_next  = hold_reg;
    zdone_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ld_start) begin
          if (ld_len != '0) begin
            state_next = ST_LOAD;
            ptr_next   = ld_base;
            cnt_next   = ld_len;
            hold_next  = 1'b1;
          end else begin
            zdone_next = 1'b1;
            hold_next  = 1'b0;
          end
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          ptr_next = ptr_reg + 1'b1;  // natural wrap: DEPTH is a power of two
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == 1) begin
            state_next = ST_DONE;
            hold_next  = 1'b0;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign we = (state_reg == ST_LOAD) && ld_valid;
  assign re = (state_reg == ST_IDLE) && f_req;

`ifdef SM_IMEM_PARITY_EN
  assign wdata = {even_parity(64'(ld_data)), ld_data};
  assign f_err = f_rvalid_reg && (even_parity(64'(rdata[DATA_W-1:0])) != rdata[DATA_W]);
`else
  assign wdata = ld_data;
  assign f_err = 1'b0;
`endif

  sm_imem_ram #(
    .W      (RAM_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (ptr_reg),
    .wdata (wdata),
    .re    (re),
    .raddr (f_addr),
    .rdata (rdata)
  );

  assign f_rvalid  = f_rvalid_reg;
  assign f_rdata   = rdata[DATA_W-1:0];
  assign ld_ready  = (state_reg == ST_LOAD);
  assign ld_busy   = (state_reg == ST_LOAD);
  assign ld_done   = (state_reg == ST_DONE) || zdone_reg;
  assign core_hold = hold_reg;
  assign node_id   = 8'(NODE_ID);

endmodule

// File: tb/tb_sm_imem_loadable.sv
// Scoreboard bench for sm_imem_loadable (default DEPTH=128, HOLD_AT_RESET=1).
// Parity scenario is compiled in only when SM_IMEM_PARITY_EN is defined.
module tb_sm_imem_loadable;

  localparam int DW = 32;
  localparam int DEPTH = 128;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;
  logic          f_err;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic [AW:0]   ld_len;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          ld_busy;
  logic          ld_done;
  logic          core_hold;
  logic [7:0]    node_id;

  sm_imem_loadable dut (
    .clk(clk), .rst_n(rst_n), .f_req(f_req), .f_addr(f_addr), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err), .ld_start(ld_start), .ld_base(ld_base),
    .ld_len(ld_len), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_busy(ld_busy), .ld_done(ld_done), .core_hold(core_hold), .node_id(node_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] exp_mem [DEPTH];
  logic          exp_bad [DEPTH];
  logic [DW-1:0] words [$];
  logic [DW-1:0] last_exp;
  int total = 0;
  int bad = 0;

  // Fetch responses are popped from the scoreboard whenever f_rvalid is seen.
  always @(negedge clk) begin
    if (f_rvalid !== 1'b0) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rvalid: got f_rvalid=%b f_rdata=%h, required no response", f_rvalid, f_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (f_rdata !== e.data || f_err !== e.err) begin
          bad++;
          $display("FAIL fetch_data: got %h err=%b, required %h err=%b", f_rdata, f_err, e.data, e.err);
        end else
          $display("fetch ok: data=%h err=%b", f_rdata, f_err);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic do_load(input int base, input int len, input int gap_at,
                         input int inject_at, input int abort_after);
    int acc = 0;
    int budget = 0;
    bit gapped = 0;
    bit injected = 0;
    bit early = 0;
    @(negedge clk);
    ld_start = 1'b1; ld_base = AW'(base); ld_len = (AW+1)'(len);
    @(negedge clk);
    ld_start = 1'b0;
    if (len == 0) begin
      chk("zlen_done", 32'(ld_done), 32'd1);
      chk("zlen_busy", 32'(ld_busy), 32'd0);
      chk("zlen_hold", 32'(core_hold), 32'd0);
      @(negedge clk);
      chk("zlen_done_pulse", 32'(ld_done), 32'd0);
      $display("load base=%0d len=0 done", base);
      return;
    end
    chk("load_busy", 32'(ld_busy), 32'd1);
    chk("load_hold", 32'(core_hold), 32'd1);
    while (acc < len && budget < 200) begin
      if (abort_after >= 0 && acc == abort_after) begin
        rst_n = 1'b0; ld_valid = 1'b0; f_req = 1'b0;
        @(negedge clk);
        chk("abort_hold", 32'(core_hold), 32'd1);
        chk("abort_busy", 32'(ld_busy), 32'd0);
        chk("abort_ready", 32'(ld_ready), 32'd0);
        chk("abort_rvalid", 32'(f_rvalid), 32'd0);
        rst_n = 1'b1;
        $display("load base=%0d aborted after %0d words", base, acc);
        return;
      end
      f_req = 1'b1; f_addr = AW'(3);
      if (acc == gap_at && !gapped) begin
        ld_valid = 1'b0;
        gapped = 1;
      end else begin
        ld_valid = 1'b1;
        ld_data = words[acc];
      end
      if (acc == inject_at && !injected) begin
        ld_start = 1'b1; ld_base = '0; ld_len = 1;
        injected = 1;
      end else
        ld_start = 1'b0;
      if (ld_done !== 1'b0) early = 1;
      if (ld_valid && ld_ready === 1'b1) begin
        exp_mem[(base + acc) % DEPTH] = words[acc];
        exp_bad[(base + acc) % DEPTH] = 1'b0;
        acc++;
      end
      @(negedge clk);
      budget++;
    end
    ld_valid = 1'b0; ld_start = 1'b0; f_req = 1'b0;
    chk("load_budget", 32'(budget < 200), 32'd1);
    chk("load_no_early_done", 32'(early), 32'd0);
    chk("done_pulse", 32'(ld_done), 32'd1);
    chk("done_ready", 32'(ld_ready), 32'd0);
    chk("done_hold", 32'(core_hold), 32'd0);
    chk("done_busy", 32'(ld_busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(ld_done), 32'd0);
    $display("load base=%0d len=%0d done", base, len);
  endtask

  task automatic fetch_seq(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      int a;
      exp_t e;
      a = (start + i) % DEPTH;
      @(negedge clk);
      f_req = 1'b1; f_addr = AW'(a);
      e.data = exp_mem[a] ^ {{(DW-1){1'b0}}, exp_bad[a]};
      e.err = exp_bad[a];
      sb.push_back(e);
      last_exp = e.data;
    end
    @(negedge clk);
    f_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("rdata_hold", f_rdata, last_exp);
  endtask

  task automatic test_reset;
    chk("rst_hold", 32'(core_hold), 32'd1);
    chk("rst_rvalid", 32'(f_rvalid), 32'd0);
    chk("rst_rdata", f_rdata, 32'd0);
    chk("rst_err", 32'(f_err), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_busy", 32'(ld_busy), 32'd0);
    chk("rst_done", 32'(ld_done), 32'd0);
    chk("rst_node", 32'(node_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_hold", 32'(core_hold), 32'd1);
  endtask

  task automatic test_basic_load;
    words = '{32'h00500293, 32'h005282b3, 32'hfe000ae3};
    do_load(0, 3, 1, -1, -1);
    fetch_seq(0, 3);
  endtask

  task automatic test_wrap;
    words = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4};
    do_load(126, 4, -1, -1, -1);
    fetch_seq(126, 4);
    fetch_seq(0, 1);
    chk("wrap_addr0", f_rdata, 32'hC3C3C3C3);
  endtask

  task automatic test_zero_len_and_ignore;
    do_load(0, 0, -1, -1, -1);
    fetch_seq(0, 2);
    words = '{32'h11111111, 32'h22222222, 32'h33333333};
    do_load(10, 3, -1, 1, -1);
    fetch_seq(10, 3);
    fetch_seq(0, 1);
  endtask

  task automatic test_back_to_back;
    words = '{32'h0000AAAA, 32'h0000BBBB, 32'h0000CCCC, 32'h0000DDDD, 32'h0000EEEE};
    do_load(20, 5, -1, -1, 2);
    words = '{32'h12345678};
    do_load(40, 1, -1, -1, -1);
    fetch_seq(20, 2);
    fetch_seq(40, 1);
  endtask

`ifdef SM_IMEM_PARITY_EN
  task automatic test_parity;
    words = '{32'h00000001, 32'h00000003, 32'h00000007};
    do_load(4, 3, -1, -1, -1);
    dut.u_ram.mem[5][0] = ~dut.u_ram.mem[5][0];
    exp_bad[5] = 1'b1;
    fetch_seq(4, 3);
  endtask
`endif

  initial begin
    rst_n = 1'b0; f_req = 1'b0; f_addr = '0; ld_start = 1'b0; ld_base = '0;
    ld_len = '0; ld_valid = 1'b0; ld_data = '0; last_exp = '0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = '0;
      exp_bad[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    test_reset;
    test_basic_load;
    test_wrap;
    test_zero_len_and_ignore;
    test_back_to_back;
`ifdef SM_IMEM_PARITY_EN
    test_parity;
`endif
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
